// File: rtl/counter_arbiter_if.sv
// Handshake and response bundle for counter_arbiter: two requester channels
// and the shared counter/response outputs.
interface counter_arbiter_if;
    logic       req0_valid;
    logic       req0_mode;
    logic [7:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic       req1_mode;
    logic [7:0] req1_data;
    logic       req1_ready;

    logic [7:0] count;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       wrap;

    // Requesters (or a testbench) drive the request side.
    modport master (
        output req0_valid, req0_mode, req0_data,
        input  req0_ready,
        output req1_valid, req1_mode, req1_data,
        input  req1_ready,
        input  count, rsp_valid, rsp_id, rsp_data, wrap
    );

    // The arbiter owns ready, the counter and the response.
    modport slave (
        input  req0_valid, req0_mode, req0_data,
        output req0_ready,
        input  req1_valid, req1_mode, req1_data,
        output req1_ready,
        output count, rsp_valid, rsp_id, rsp_data, wrap
    );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter guarding one shared 8-bit counter.
// Each granted op (step or overwrite) yields a registered response one cycle later.
module counter_arbiter (
    input  logic               clk,
    input  logic               rst,
    counter_arbiter_if.slave   bus
);
    typedef enum logic {
        OP_STEP      = 1'b0,
        OP_OVERWRITE = 1'b1
    } op_e;

    logic [7:0] count_q,    count_d;
    logic       ptr_q,      ptr_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q,   rsp_id_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       wrap_q,     wrap_d;

    logic       grant;
    logic       winner;
    op_e        win_op;
    logic [7:0] win_data;

    // Arbitration: a tie goes to the requester opposite the last winner.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant  = 1'b0;
        winner = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant  = 1'b1;
                winner = ~ptr_q;
            end else if (bus.req0_valid) begin
                grant  = 1'b1;
                winner = 1'b0;
            end else if (bus.req1_valid) begin
                grant  = 1'b1;
                winner = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant && (winner == 1'b0);
    assign bus.req1_ready = grant && (winner == 1'b1);

    assign win_op   = winner ? op_e'(bus.req1_mode) : op_e'(bus.req0_mode);
    assign win_data = winner ? bus.req1_data : bus.req0_data;

    always_comb begin
        count_d     = count_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        wrap_d      = wrap_q;
        if (grant) begin
            ptr_d       = winner;
            rsp_valid_d = 1'b1;
            rsp_id_d    = winner;
            rsp_data_d  = count_q;
            wrap_d      = (win_op == OP_STEP) && (count_q == 8'hFF);
            count_d     = (win_op == OP_STEP) ? count_q + 8'd1 : win_data;
        end
    end

    // Pointer resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            count_q     <= 8'h00;
            ptr_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'h00;
            wrap_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameters: none; count, load data and response data are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_mode  input  1  requester 0 op: 0 = step (+1), 1 = overwrite.
REQ-006 req0_data  input  8  requester 0 overwrite value; ignored when req0_mode = 0.
REQ-007 req0_ready  output  1  requester 0 op accepted this cycle.
REQ-008 req1_valid, req1_mode, req1_data, req1_ready SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 count  output  8  current shared counter value, registered.
REQ-010 rsp_valid  output  1  one-cycle pulse: an op completed last cycle.
REQ-011 rsp_id  output  1  requester whose op completed.
REQ-012 rsp_data  output  8  counter value immediately before the completed op.
REQ-013 wrap  output  1  completed op was a step from 8'hFF to 8'h00.

Function
REQ-014 The block SHALL own one 8-bit counter register driving count and SHALL perform at most one op per cycle.
REQ-015 Grant: only one valid -> that requester wins; both valid -> winner is the requester opposite the round-robin pointer; none valid -> no grant.
REQ-016 Round-robin pointer holds the id of the last granted requester and SHALL update on every grant, including single-requester grants.
REQ-017 reqN_ready SHALL be combinational, high only when reqN_valid is high and requester N wins this cycle; ready SHALL never assert without valid.
REQ-018 Handshake completes on valid & ready at a rising edge; requesters hold valid, mode and data stable until ready, and the block SHALL NOT rely on valid deasserting after acceptance.
REQ-019 Granted step: count <= count + 1 modulo 256; granted overwrite: count <= reqN_data.
REQ-020 No grant: count, pointer and all response outputs except rsp_valid SHALL hold; rsp_valid SHALL be 0 next cycle.
REQ-021 Response latency SHALL be exactly one cycle: at the edge completing a grant, rsp_valid <= 1, rsp_id <= winner, rsp_data <= pre-op count.
REQ-022 wrap SHALL be registered with the response and equal 1 only for a granted step while count = 8'hFF; overwrite with 8'h00 SHALL NOT set wrap.
REQ-023 Back-to-back grants SHALL produce back-to-back responses; each op sees the count left by the previous op (no lost updates).
REQ-024 A requester may change mode/data between accepted ops; each accepted op uses the mode/data sampled on its own accept edge.

Reset
REQ-025 While rst is high at a rising edge: count <= 8'h00, pointer <= 1 (requester 0 wins the first tie), rsp_valid <= 0, rsp_id <= 0, rsp_data <= 8'h00, wrap <= 0.
REQ-026 While rst is high, req0_ready and req1_ready SHALL be 0 regardless of valid; ops presented during reset are not accepted and are not queued.
REQ-027 Reset mid-operation SHALL discard any response that would have issued at that edge; the first cycle after rst deasserts SHALL arbitrate normally.

Verification
REQ-028 Reset, then req0 step held valid 3 cycles -> req0_ready high each cycle, count 1,2,3; rsp_data 0,1,2, rsp_id 0, wrap 0.
REQ-029 After reset, both requesters valid with step for 4 cycles -> grant order 0,1,0,1; count ends 4; rsp_id 0,1,0,1.
REQ-030 req1 overwrite 8'hFF, then req1 step -> count FF then 00; second response rsp_data FF, wrap 1; a following step gives wrap 0.
REQ-031 Same cycle req0 step and req1 overwrite 8'h5A with pointer = 0 -> req1 wins, count 5A; next cycle req0 wins, count 5B, rsp_data 5A, rsp_id 0.
REQ-032 rst asserted for one cycle while both valid mid-stream -> both ready 0, count 00, rsp_valid 0 next cycle; after release, req0 wins the tie.
REQ-033 req0 valid with no req1 activity for 2 grants, then both valid -> req1 wins the tie (pointer = 0 after req0 grants).
